// File: rtl/tile_renderer_if.sv
// rtl/tile_renderer_if.sv - read-only memory bus between tile_renderer and its three scanout memories
// Ports (signals):
//   tb_addr/tb_data   tile buffer read port, data valid 1 clock after address
//   tg_addr/tg_data   tile graphics read port, data valid 1 clock after address
//   pal_addr/pal_data colour palette read port {R,G,B}, data valid 1 clock after address
//   master = renderer side (drives addresses), slave = memory side (returns data)
interface tile_renderer_if;
  logic [8:0]  tb_addr;
  logic [31:0] tb_data;
  logic [10:0] tg_addr;
  logic [31:0] tg_data;
  logic [2:0]  pal_addr;
  logic [23:0] pal_data;

  modport master (
    output tb_addr, tg_addr, pal_addr,
    input  tb_data, tg_data, pal_data
  );

  modport slave (
    input  tb_addr, tg_addr, pal_addr,
    output tb_data, tg_data, pal_data
  );
endinterface

// File: rtl/tile_renderer.sv
// rtl/tile_renderer.sv - 4-stage tile scanout: tile buffer -> tile graphics -> palette -> VGA pins
// Ports:
//   clk, reset            system clock (two clocks per pixel), asynchronous active-high reset
//   enable                1 = render tiles, 0 = active area shows BG_COLOR (sampled in the last stage)
//   hcount, vcount        timing generator counters, pixel x = hcount[10:1]
//   in_hsync, in_vsync    active-low syncs from the timing generator
//   in_blank_n            1 = active video
//   mem                   read ports of tile buffer, tile graphics and palette (master side)
//   VGA_R/G/B             registered pixel colour
//   VGA_HS/VS/BLANK_n     syncs and blank delayed to line up with the pixel colour
module tile_renderer #(
  parameter int          H_TILES  = 20,
  parameter int          V_TILES  = 15,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [10:0]            hcount,
  input  logic [9:0]             vcount,
  input  logic                   in_hsync,
  input  logic                   in_vsync,
  input  logic                   in_blank_n,
  tile_renderer_if.master        mem,
  output logic [7:0]             VGA_R,
  output logic [7:0]             VGA_G,
  output logic [7:0]             VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_n
);

  localparam logic [5:0] HT6 = 6'(H_TILES);
  localparam logic [5:0] VT6 = 6'(V_TILES);
  localparam logic [8:0] HT9 = 9'(H_TILES);

  // Stage 0: tile column is hcount[10:6] and tile row is vcount[9:5], so
  // comparing them against the tile counts is the same as hcount < 1280
  // and vcount < 480 for a 20x15 screen of 32x32 tiles.
  logic       active0;
  logic [8:0] row_base;

  assign active0  = in_blank_n
                  && ({1'b0, hcount[10:6]} < HT6)
                  && ({1'b0, vcount[9:5]}  < VT6);
  assign row_base = 9'(vcount[8:5]) * HT9;

  // Reset also forces the address low so the pins show their reset value
  // without waiting for a clock edge.
  assign mem.tb_addr = (active0 && !reset) ? (row_base + 9'(hcount[10:6])) : 9'd0;

  // Stage 1 registers
  logic       s1_active;
  logic [4:0] s1_xt;
  logic [4:0] s1_yt;
  logic       s1_hs, s1_vs, s1_bl;

  // Stage 2 registers
  logic       s2_active;
  logic [2:0] s2_x;
  logic       s2_hs, s2_vs, s2_bl;

  // Stage 3 registers
  logic       s3_active;
  logic       s3_trans;
  logic       s3_hs, s3_vs, s3_bl;

  // Stage 1: word within the tile is row*4 + (x / 8); gated by active so
  // inactive pixels and the reset state never issue stray addresses.
  assign mem.tg_addr = s1_active ? {mem.tb_data[3:0], s1_yt, s1_xt[4:3]} : 11'd0;

  // Stage 2: pick the 4-bit pixel out of the 8-pixel word, pixel 0 in the LSBs.
  logic [3:0] nib;
  assign nib          = mem.tg_data[{s2_x, 2'b00} +: 4];
  assign mem.pal_addr = s2_active ? nib[2:0] : 3'd0;

  // Stage 3: colour select
  logic [23:0] rgb_next;
  always_comb begin
    rgb_next = 24'h000000;
    if (s3_active) begin
      if (!enable || s3_trans) rgb_next = BG_COLOR;
      else                     rgb_next = mem.pal_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_active   <= 1'b0;
      s1_xt       <= 5'd0;
      s1_yt       <= 5'd0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_bl       <= 1'b0;
      s2_active   <= 1'b0;
      s2_x        <= 3'd0;
      s2_hs       <= 1'b1;
      s2_vs       <= 1'b1;
      s2_bl       <= 1'b0;
      s3_active   <= 1'b0;
      s3_trans    <= 1'b0;
      s3_hs       <= 1'b1;
      s3_vs       <= 1'b1;
      s3_bl       <= 1'b0;
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
    end else begin
      s1_active   <= active0;
      s1_xt       <= hcount[5:1];
      s1_yt       <= vcount[4:0];
      s1_hs       <= in_hsync;
      s1_vs       <= in_vsync;
      s1_bl       <= in_blank_n;

      s2_active   <= s1_active;
      s2_x        <= s1_xt[2:0];
      s2_hs       <= s1_hs;
      s2_vs       <= s1_vs;
      s2_bl       <= s1_bl;

      s3_active   <= s2_active;
      s3_trans    <= nib[3];
      s3_hs       <= s2_hs;
      s3_vs       <= s2_vs;
      s3_bl       <= s2_bl;

      VGA_R       <= rgb_next[23:16];
      VGA_G       <= rgb_next[15:8];
      VGA_B       <= rgb_next[7:0];
      VGA_HS      <= s3_hs;
      VGA_VS      <= s3_vs;
      VGA_BLANK_n <= s3_bl;
    end
  end

  // Upper tile buffer bits and the half-pixel bit of hcount carry no information here.
  logic unused_bits;
  assign unused_bits = ^{mem.tb_data[31:4], hcount[0]};

endmodule

// File: tb/tb_tile_renderer.sv
// tb/tb_tile_renderer.sv - randomized scoreboard bench for tile_renderer with memory models
module tb_tile_renderer;

  localparam int          H_TILES = 20;
  localparam int          V_TILES = 15;
  localparam logic [23:0] BG      = 24'h5A5A5A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        in_hsync = 1'b1;
  logic        in_vsync = 1'b1;
  logic        in_blank_n = 1'b0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_n;

  tile_renderer_if bus ();

  tile_renderer #(.H_TILES(H_TILES), .V_TILES(V_TILES), .BG_COLOR(BG)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .hcount     (hcount),
    .vcount     (vcount),
    .in_hsync   (in_hsync),
    .in_vsync   (in_vsync),
    .in_blank_n (in_blank_n),
    .mem        (bus),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK_n(VGA_BLANK_n)
  );

  always #5 clk = ~clk;

  // Memory models: synchronous read, one clock latency
  logic [31:0] tbuf [512];
  logic [31:0] tgfx [2048];
  logic [23:0] pal  [8];

  always @(posedge clk) begin
    bus.tb_data  <= tbuf[bus.tb_addr];
    bus.tg_data  <= tgfx[bus.tg_addr];
    bus.pal_data <= pal[bus.pal_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Input history, ring of 8, indexed by absolute cycle number
  int hq [8];
  int vq [8];
  bit blq[8], hsq[8], vsq[8], enq[8];
  int cnt = 0;

  // Reference: what a pixel at (h, v) should look like, straight from the
  // screen geometry: 32x32 tiles, 8 pixels per word, 4 words per tile row.
  function automatic void model(input int i, output bit act, output int tba,
                                output int tga, output int nib);
    int h, v, x, tile;
    h   = hq[i % 8];
    v   = vq[i % 8];
    x   = h / 2;
    act = blq[i % 8] && (h < 1280) && (v < 480);
    tba = 0;
    tga = 0;
    nib = 0;
    if (act) begin
      tba  = (v / 32) * H_TILES + (h / 64);
      tile = int'(tbuf[tba][3:0]);
      tga  = tile * 128 + (v % 32) * 4 + (x % 32) / 8;
      nib  = int'((tgfx[tga] >> (4 * (x % 8))) & 32'hF);
    end
  endfunction

  // Called at a falling edge before new inputs go out:
  // outputs show cycle cnt-4, palette address cnt-2, tile addresses cnt-1.
  task automatic score();
    bit act;
    int tba, tga, nib;
    logic [23:0] exp_rgb;
    model(cnt - 4, act, tba, tga, nib);
    if (!act)                             exp_rgb = 24'h000000;
    else if (!enq[(cnt - 1) % 8] || nib[3]) exp_rgb = BG;
    else                                  exp_rgb = pal[nib & 7];
    check("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_rgb));
    check("hs", 32'(VGA_HS), 32'(hsq[(cnt - 4) % 8]));
    check("vs", 32'(VGA_VS), 32'(vsq[(cnt - 4) % 8]));
    check("blank_n", 32'(VGA_BLANK_n), 32'(blq[(cnt - 4) % 8]));
    model(cnt - 2, act, tba, tga, nib);
    if (act) check("pal_addr", 32'(bus.pal_addr), 32'(nib & 7));
    model(cnt - 1, act, tba, tga, nib);
    check("tb_addr", 32'(bus.tb_addr), 32'(tba));
    if (act) check("tg_addr", 32'(bus.tg_addr), 32'(tga));
  endtask

  task automatic drive(input int h, input int v, input bit bl, input bit hs,
                       input bit vs, input bit en);
    score();
    hcount     = h[10:0];
    vcount     = v[9:0];
    in_blank_n = bl;
    in_hsync   = hs;
    in_vsync   = vs;
    enable     = en;
    hq[cnt % 8]  = h;
    vq[cnt % 8]  = v;
    blq[cnt % 8] = bl;
    hsq[cnt % 8] = hs;
    vsq[cnt % 8] = vs;
    enq[cnt % 8] = en;
    cnt++;
  endtask

  task automatic step(input int h, input int v, input bit bl, input bit hs,
                      input bit vs, input bit en);
    drive(h, v, bl, hs, vs, en);
    @(negedge clk);
  endtask

  // Hold reset with idle inputs, seed history with the reset state, release
  // on a falling edge.
  task automatic reset_release();
    @(negedge clk);
    reset      = 1'b1;
    hcount     = '0;
    vcount     = '0;
    in_blank_n = 1'b0;
    in_hsync   = 1'b1;
    in_vsync   = 1'b1;
    enable     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hq[i] = 0; vq[i] = 0; blq[i] = 0; hsq[i] = 1; vsq[i] = 1; enq[i] = 1;
    end
    cnt = 4;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [10:0] exp_tg;
    bit en_r;
    int v_r;

    for (int i = 0; i < 512; i++)  tbuf[i] = $urandom;
    for (int i = 0; i < 2048; i++) tgfx[i] = $urandom;
    for (int i = 0; i < 8; i++)    pal[i]  = 24'($urandom);
    tbuf[0]        = 32'h0000_0001;
    tgfx[128][3:0] = 4'h3;
    tbuf[21]       = 32'hFFFF_FFF5;
    tgfx[640]      = 32'h000A_2000;
    pal[2]         = 24'h12AB34;

    reset_release();

    // Mid-line reset: outputs go to reset values with no clock edge
    for (int i = 0; i < 8; i++) step(300, 10, 1, 1, 1, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
    check("rst_hs", 32'(VGA_HS), 32'h1);
    check("rst_vs", 32'(VGA_VS), 32'h1);
    check("rst_blank_n", 32'(VGA_BLANK_n), 32'h0);
    check("rst_tb_addr", 32'(bus.tb_addr), 32'h0);
    check("rst_tg_addr", 32'(bus.tg_addr), 32'h0);
    check("rst_pal_addr", 32'(bus.pal_addr), 32'h0);
    reset_release();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1, 1);
    check("first_pixel", 32'({VGA_R, VGA_G, VGA_B}), 32'(pal[3]));
    for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 1, 1);

    // Tile 5 at buffer entry 21, pixel 3 opaque, pixel 4 transparent
    drive(70, 32, 1, 1, 1, 1);
    #1 check("t2_tb_addr", 32'(bus.tb_addr), 32'd21);
    @(negedge clk);
    check("t2_tg_addr", 32'(bus.tg_addr), 32'd640);
    step(70, 32, 1, 1, 1, 1);
    check("t2_pal_addr", 32'(bus.pal_addr), 32'd2);
    step(72, 32, 1, 1, 1, 1);
    step(72, 32, 1, 1, 1, 1);
    check("t2_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h12AB34);
    check("t4_pal_addr", 32'(bus.pal_addr), 32'd2);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    check("t4_trans_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(BG));
    for (int i = 0; i < 4; i++) step(70, 32, 1, 1, 1, 0);
    check("t4_disabled_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(BG));

    // Last tile on screen
    drive(1278, 479, 1, 1, 1, 1);
    #1 check("t3_tb_addr", 32'(bus.tb_addr), 32'd299);
    @(negedge clk);
    exp_tg = {tbuf[299][3:0], 5'd31, 2'd3};
    check("t3_tg_addr", 32'(bus.tg_addr), 32'(exp_tg));
    step(1278, 479, 1, 1, 1, 1);

    // Out-of-range coordinates with blank_n high
    drive(1300, 100, 1, 1, 1, 1);
    #1 check("t5_tb_addr_h", 32'(bus.tb_addr), 32'd0);
    @(negedge clk);
    drive(100, 500, 1, 1, 1, 1);
    #1 check("t5_tb_addr_v", 32'(bus.tb_addr), 32'd0);
    @(negedge clk);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    check("t5_rgb_h", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
    step(0, 0, 0, 1, 1, 1);
    check("t5_rgb_v", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);

    // Random full-width scan lines with random syncs and enable toggles
    for (int line = 0; line < 12; line++) begin
      v_r  = int'($urandom_range(0, 524));
      en_r = ($urandom_range(0, 3) != 0);
      for (int h = 0; h < 1600; h++) begin
        bit bl;
        bl = (h < 1280) && (v_r < 480);
        if ($urandom_range(0, 63) == 0) bl = ~bl;
        if ($urandom_range(0, 199) == 0) en_r = ~en_r;
        step(h, v_r, bl, 1'($urandom), 1'($urandom), en_r);
      end
    end

    // Random pixel jumps over the whole counter range
    for (int i = 0; i < 20000; i++) begin
      step(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
           ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) != 0));
    end

    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
